axi_slave_write: RTL



---
 rtl/axi_slave_write.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axi_slave_write.sv
// AXI4 write-channel slave: accepts AW, writes each W beat straight into a word SRAM, returns one B.
// Optional address range check is enabled by defining AXI_SLAVE_WRITE_RANGE_CHECK_EN.
module axi_slave_write #(
   parameter int unsigned ID_W       = 8,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF,
   parameter int unsigned MEM_AW     = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   AWID_S,
   input  logic [31:0]       AWADDR_S,
   input  logic [3:0]        AWLEN_S,
   input  logic [2:0]        AWSIZE_S,
   input  logic [1:0]        AWBURST_S,
   input  logic              AWVALID_S,
   output logic              AWREADY_S,
   input  logic [31:0]       WDATA_S,
   input  logic [3:0]        WSTRB_S,
   input  logic              WLAST_S,
   input  logic              WVALID_S,
   output logic              WREADY_S,
   output logic [ID_W-1:0]   BID_S,
   output logic [1:0]        BRESP_S,
   output logic              BVALID_S,
   input  logic              BREADY_S,
   output logic              mem_cs,
   output logic [3:0]        mem_web,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_di
);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      len_q, len_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [31:0]     addr_q, addr_d;
   logic [1:0]      burst_q, burst_d;
   logic            err_q, err_d;
   logic            oor_q, oor_d;
   logic            aw_oor;
   logic            final_beat;
   logic            unused_size;

   // Every beat is treated as 4 bytes regardless of AWSIZE_S.
   assign unused_size = ^AWSIZE_S;

`ifdef AXI_SLAVE_WRITE_RANGE_CHECK_EN
   logic [32:0] aw_end;
   always_comb begin
      aw_end = {1'b0, AWADDR_S} + {27'd0, AWLEN_S, 2'b00};
      aw_oor = ({1'b0, AWADDR_S} < {1'b0, ADDR_BASE}) || (aw_end > {1'b0, ADDR_LIMIT});
   end
`else
   logic unused_cfg;
   assign aw_oor     = 1'b0;
   assign unused_cfg = ^{ADDR_BASE, ADDR_LIMIT};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      id_d       = id_q;
      addr_d     = addr_q;
      burst_d    = burst_q;
      err_d      = err_q;
      oor_d      = oor_q;
      final_beat = (cnt_q == len_q);
      AWREADY_S  = 1'b0;
      WREADY_S   = 1'b0;
      BVALID_S   = 1'b0;
      BID_S      = '0;
      BRESP_S    = 2'b00;
      mem_cs     = 1'b0;
      mem_web    = '1;
      mem_addr   = '0;
      mem_di     = '0;
      // Outputs are held at their reset values for the whole time rst is high.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               AWREADY_S = 1'b1;
               if (AWVALID_S) begin
                  id_d    = AWID_S;
                  addr_d  = AWADDR_S;
                  len_d   = AWLEN_S;
                  burst_d = AWBURST_S;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  oor_d   = aw_oor;
                  state_d = DATA;
               end
            end
            DATA: begin
               WREADY_S = 1'b1;
               if (WVALID_S) begin
                  if (!oor_q) begin
                     mem_cs   = 1'b1;
                     mem_web  = ~WSTRB_S;
                     mem_addr = addr_q[MEM_AW+1:2];
                     mem_di   = WDATA_S;
                  end
                  if (burst_q != 2'b00) begin
                     addr_d = addr_q + 32'd4;
                  end
                  cnt_d = cnt_q + 4'd1;
                  if (WLAST_S != final_beat) begin
                     err_d = 1'b1;
                  end
                  if (final_beat) begin
                     state_d = RESP;
                  end
               end
            end
            RESP: begin
               BVALID_S = 1'b1;
               BID_S    = id_q;
               BRESP_S  = (err_q || oor_q) ? 2'b10 : 2'b00;
               if (BREADY_S) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         err_q   <= err_d;
         oor_q   <= oor_d;
      end
   end

endmodule
